// File: rtl/uart_pkg.sv
// uart_pkg: shared types and frame constants
// for the byte-wide 8N1 UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  function automatic int unsigned clks_per_bit(
    input int unsigned clk_hz,
    input int unsigned baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter, one-cycle
// tick on the last cycle of each serial bit.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick_o = en_i & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: 8N1 transmitter, one frame per
// qualified rising edge of tx_ready_i.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
  parameter int unsigned BAUD_RATE    = 115_200,
  parameter int unsigned CLKS_PER_BIT =
    clks_per_bit(CLK_FREQ_HZ, BAUD_RATE)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_ready_i,
  input  logic       rx_ready_i,
  input  logic [7:0] data_i,
  output logic       data_o
);

  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  tx_state_e  state_q, state_d;
  logic       req_q;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_q, bit_d;
  logic       tx_q, tx_d;
  logic       start;
  logic       bit_done;

  assign start = tx_ready_i & ~req_q & rx_ready_i
               & (state_q == IDLE);
  assign data_o = tx_q;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (state_q == IDLE),
    .en_i   (state_q != IDLE),
    .tick_o (bit_done)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = data_i;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == BIT_LAST) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level follows the next state so data_o stays a clean flop.
  always_comb begin
    tx_d = 1'b1;
    unique case (1'b1)
      (state_d == START): tx_d = 1'b0;
      (state_d == DATA):  tx_d = shift_d[0];
      default:            tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b1;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      req_q   <= tx_ready_i;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: directed and random frames checked
// against an ideal 8N1 waveform model.
module tb_uart_tx_core;

  localparam int CPB = 868;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_ready_i;
  logic       rx_ready_i;
  logic [7:0] data_i;
  logic       data_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_ready_i (tx_ready_i),
    .rx_ready_i (rx_ready_i),
    .data_i     (data_i),
    .data_o     (data_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bit n of the ideal frame: start 0, data LSB first, stop 1.
  function automatic logic exp_bit(input logic [7:0] d, input int n);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    return fr[n];
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input int n, input string tag);
    int bad;
    bad = 0;
    repeat (n) begin
      if (data_o !== 1'b1) bad++;
      step();
    end
    check(tag, bad, 0);
  endtask

  task automatic send_frame(
    input logic [7:0] d,
    input string      tag,
    input int         chg_at,
    input logic [7:0] chg_d,
    input int         req_at,
    input int         abort_at,
    input bit         rx_wiggle
  );
    int lat;
    int bad;
    lat = 0;
    bad = 0;
    data_i     = d;
    rx_ready_i = 1'b1;
    tx_ready_i = 1'b1;
    step();
    while (data_o !== 1'b0 && lat < 4) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, lat, 0);
    for (int i = 0; i < 10 * CPB; i++) begin
      if (i == abort_at) begin
        rst_n      = 1'b0;
        tx_ready_i = 1'b0;
        step();
        check({tag, "_abort_out"}, int'(data_o), 1);
        rst_n = 1'b1;
        break;
      end
      if (data_o !== exp_bit(d, i / CPB)) bad++;
      if (i == 1000) tx_ready_i = 1'b0;
      if (i == chg_at) data_i = chg_d;
      if (i == req_at - 20) tx_ready_i = 1'b0;
      if (i == req_at) begin
        tx_ready_i = 1'b1;
        data_i     = 8'($urandom);
      end
      if (i == req_at + 50) tx_ready_i = 1'b0;
      if (rx_wiggle && (i % 500) == 0) rx_ready_i = ~rx_ready_i;
      step();
    end
    check({tag, "_bits"}, bad, 0);
  endtask

  initial begin
    logic [7:0] r;
    rst_n      = 1'b0;
    tx_ready_i = 1'b1;
    rx_ready_i = 1'b1;
    data_i     = 8'h00;
    repeat (5) step();
    check("rst_out", int'(data_o), 1);
    rst_n = 1'b1;
    idle_chk(1000, "held_across_rst");
    tx_ready_i = 1'b0;
    idle_chk(1000, "idle");

    send_frame(8'h55, "basic", -1, 8'h00, -1, -1, 1'b0);
    idle_chk(2000, "basic_after");

    rx_ready_i = 1'b0;
    data_i     = 8'hA5;
    tx_ready_i = 1'b1;
    step();
    tx_ready_i = 1'b0;
    idle_chk(500, "not_ready");
    rx_ready_i = 1'b1;
    idle_chk(500, "rx_late");

    send_frame(8'h0F, "stable", 2000, 8'hF0, -1, -1, 1'b0);
    idle_chk(200, "stable_after");

    r = 8'($urandom);
    send_frame(r, "busy", -1, 8'h00, 3000, -1, 1'b0);
    idle_chk(1500, "busy_not_queued");
    r = 8'($urandom);
    send_frame(r, "busy2", -1, 8'h00, -1, -1, 1'b0);
    idle_chk(100, "busy2_after");

    r = 8'($urandom);
    send_frame(r, "rx_mid", -1, 8'h00, -1, -1, 1'b1);
    idle_chk(100, "rx_mid_after");

    r = 8'($urandom);
    send_frame(r, "abort", -1, 8'h00, -1, 4000, 1'b0);
    idle_chk(1500, "abort_idle");
    r = 8'($urandom);
    send_frame(r, "fresh", -1, 8'h00, -1, -1, 1'b0);
    idle_chk(100, "fresh_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
